// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared types and sizing helpers for the input debouncer
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    QUAL_HI   = 2'd1,
    STABLE_HI = 2'd2,
    QUAL_LO   = 2'd3
  } deb_state_t;

  localparam int REJECT_CNT_W = 8;

  // Qualification counter width; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return ($clog2(cycles) < 1) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - multi-flop synchronizer with asynchronous clear
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the raw input one stage per clock; nothing sits between stages.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // Stage registers, cleared asynchronously so reset needs no clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - synchronizes and debounces one raw input, counts rejected glitches
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    din_async,
  output logic                    din_clean,
  output logic                    busy,
  output logic [REJECT_CNT_W-1:0] reject_cnt
);

  localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic s;

  deb_state_t              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    din_clean_q, din_clean_d;
  logic [REJECT_CNT_W-1:0] reject_q, reject_d;
  logic                    abort;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (din_async),
    .q  (s)
  );

  // Next-state logic: the entry sample counts as the first of DEBOUNCE_CYCLES.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    din_clean_d = din_clean_q;
    reject_d    = reject_q;
    abort       = 1'b0;
    case (state_q)
      STABLE_LO: begin
        if (s) begin
          state_d = QUAL_HI;
          cnt_d   = CNT_ONE;
        end
      end
      QUAL_HI: begin
        if (!s) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
          abort   = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = STABLE_HI;
          din_clean_d = 1'b1;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!s) begin
          state_d = QUAL_LO;
          cnt_d   = CNT_ONE;
        end
      end
      QUAL_LO: begin
        if (s) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
          abort   = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = STABLE_LO;
          din_clean_d = 1'b0;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d     = STABLE_LO;
        cnt_d       = '0;
        din_clean_d = 1'b0;
      end
    endcase
    // Saturating reject counter, stepped on the same edge as the abort.
    if (abort && (reject_q != {REJECT_CNT_W{1'b1}})) begin
      reject_d = reject_q + 1'b1;
    end
  end

  // FSM, counter and output registers; reset drops any partial qualification.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= STABLE_LO;
      cnt_q       <= '0;
      din_clean_q <= 1'b0;
      reject_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      din_clean_q <= din_clean_d;
      reject_q    <= reject_d;
    end
  end

  assign din_clean  = din_clean_q;
  assign busy       = (state_q == QUAL_HI) || (state_q == QUAL_LO);
  assign reject_cnt = reject_q;

endmodule

// File: tb/tb_input_debouncer.sv
// tb/tb_input_debouncer.sv - directed scoreboard bench for input_debouncer
module tb_input_debouncer;

  logic       clk = 1'b0;
  logic       rst;
  logic       din_async;
  logic       din_clean;
  logic       busy;
  logic [7:0] reject_cnt;

  input_debouncer #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din_async (din_async),
    .din_clean (din_clean),
    .busy      (busy),
    .reject_cnt(reject_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         edge_no;
    string      tag;
    logic       clean;
    logic       busy;
    logic [7:0] rej;
  } exp_t;

  exp_t sb[$];
  int   edge_no     = 0;
  int   vectors     = 0;
  int   miscompares = 0;
  int   rises       = 0;
  logic prev_clean  = 1'b0;

  task automatic compare(input string tag, input logic [7:0] got, input logic [7:0] want);
    vectors++;
    assert (got === want)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic check_due();
    exp_t e;
    while (sb.size() > 0 && sb[0].edge_no <= edge_no) begin
      e = sb.pop_front();
      if (e.edge_no < edge_no) begin
        vectors++;
        miscompares++;
        $error("FAIL %s: expectation for edge %0d skipped at edge %0d", e.tag, e.edge_no, edge_no);
      end else begin
        compare({e.tag, ".din_clean"}, {7'd0, din_clean}, {7'd0, e.clean});
        compare({e.tag, ".busy"}, {7'd0, busy}, {7'd0, e.busy});
        compare({e.tag, ".reject_cnt"}, reject_cnt, e.rej);
      end
    end
  endtask

  task automatic expect_at(input int e, input string tag, input logic c, input logic b,
                           input logic [7:0] r);
    exp_t x;
    x.edge_no = e;
    x.tag     = tag;
    x.clean   = c;
    x.busy    = b;
    x.rej     = r;
    sb.push_back(x);
  endtask

  task automatic check_now(input string tag, input logic c, input logic b, input logic [7:0] r);
    exp_t x;
    x.edge_no = edge_no;
    x.tag     = tag;
    x.clean   = c;
    x.busy    = b;
    x.rej     = r;
    sb.push_front(x);
    check_due();
  endtask

  task automatic tick();
    @(posedge clk);
    edge_no++;
    @(negedge clk);
    if (din_clean && !prev_clean) rises++;
    prev_clean = din_clean;
    check_due();
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    int   n;
    int   rises_before;
    logic bounce [6];
    bounce = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    // Reset asserted with the raw input high.
    rst       = 1'b0;
    din_async = 1'b1;
    #2 rst = 1'b1;
    #1 check_now("rst_async", 1'b0, 1'b0, 8'd0);
    expect_at(1, "rst_hold1", 1'b0, 1'b0, 8'd0);
    expect_at(2, "rst_hold2", 1'b0, 1'b0, 8'd0);
    expect_at(3, "rst_hold3", 1'b0, 1'b0, 8'd0);
    ticks(3);

    // Release with input high: din_clean rises after the fifth edge.
    rst = 1'b0;
    n   = edge_no + 1;
    expect_at(n + 1, "rel_e1", 1'b0, 1'b0, 8'd0);
    expect_at(n + 2, "rel_e2", 1'b0, 1'b1, 8'd0);
    expect_at(n + 3, "rel_e3", 1'b0, 1'b1, 8'd0);
    expect_at(n + 4, "rel_e4", 1'b0, 1'b1, 8'd0);
    expect_at(n + 5, "rel_e5", 1'b1, 1'b0, 8'd0);
    expect_at(n + 6, "rel_e6", 1'b1, 1'b0, 8'd0);
    ticks(7);

    // Bounce 0/1 six times from stable high, then settle low.
    n = edge_no + 1;
    expect_at(n + 1,  "bnc_e1",  1'b1, 1'b0, 8'd0);
    expect_at(n + 2,  "bnc_e2",  1'b1, 1'b1, 8'd0);
    expect_at(n + 3,  "bnc_e3",  1'b1, 1'b0, 8'd1);
    expect_at(n + 4,  "bnc_e4",  1'b1, 1'b1, 8'd1);
    expect_at(n + 5,  "bnc_e5",  1'b1, 1'b0, 8'd2);
    expect_at(n + 6,  "bnc_e6",  1'b1, 1'b1, 8'd2);
    expect_at(n + 7,  "bnc_e7",  1'b1, 1'b0, 8'd3);
    expect_at(n + 8,  "bnc_e8",  1'b1, 1'b1, 8'd3);
    expect_at(n + 9,  "bnc_e9",  1'b1, 1'b1, 8'd3);
    expect_at(n + 10, "bnc_e10", 1'b1, 1'b1, 8'd3);
    expect_at(n + 11, "bnc_e11", 1'b0, 1'b0, 8'd3);
    expect_at(n + 12, "bnc_e12", 1'b0, 1'b0, 8'd3);
    for (int k = 0; k < 6; k++) begin
      din_async = bounce[k];
      tick();
    end
    din_async = 1'b0;
    ticks(7);

    // Clean rise: exactly one rising edge seen downstream.
    rises_before = rises;
    n            = edge_no + 1;
    din_async    = 1'b1;
    expect_at(n + 1, "rise_e1", 1'b0, 1'b0, 8'd3);
    expect_at(n + 2, "rise_e2", 1'b0, 1'b1, 8'd3);
    expect_at(n + 3, "rise_e3", 1'b0, 1'b1, 8'd3);
    expect_at(n + 4, "rise_e4", 1'b0, 1'b1, 8'd3);
    expect_at(n + 5, "rise_e5", 1'b1, 1'b0, 8'd3);
    expect_at(n + 6, "rise_e6", 1'b1, 1'b0, 8'd3);
    ticks(8);
    compare("rise_edge_pulses", 8'(rises - rises_before), 8'd1);

    // Return low, then a two-cycle glitch.
    din_async = 1'b0;
    ticks(8);
    check_now("fall_done", 1'b0, 1'b0, 8'd3);
    n         = edge_no + 1;
    din_async = 1'b1;
    expect_at(n + 1, "glt_e1", 1'b0, 1'b0, 8'd3);
    expect_at(n + 2, "glt_e2", 1'b0, 1'b1, 8'd3);
    expect_at(n + 3, "glt_e3", 1'b0, 1'b1, 8'd3);
    expect_at(n + 4, "glt_e4", 1'b0, 1'b0, 8'd4);
    expect_at(n + 5, "glt_e5", 1'b0, 1'b0, 8'd4);
    expect_at(n + 6, "glt_e6", 1'b0, 1'b0, 8'd4);
    ticks(2);
    din_async = 1'b0;
    ticks(5);

    // Reset in QUAL_HI with cnt=2, then full latency again.
    n         = edge_no + 1;
    din_async = 1'b1;
    expect_at(n + 2, "mid_e2", 1'b0, 1'b1, 8'd4);
    expect_at(n + 3, "mid_e3", 1'b0, 1'b1, 8'd4);
    ticks(4);
    rst = 1'b1;
    #1 check_now("mid_rst", 1'b0, 1'b0, 8'd0);
    ticks(2);
    rst = 1'b0;
    n   = edge_no + 1;
    expect_at(n + 1, "post_e1", 1'b0, 1'b0, 8'd0);
    expect_at(n + 2, "post_e2", 1'b0, 1'b1, 8'd0);
    expect_at(n + 4, "post_e4", 1'b0, 1'b1, 8'd0);
    expect_at(n + 5, "post_e5", 1'b1, 1'b0, 8'd0);
    ticks(6);

    // Saturation with 300 isolated one-cycle glitches.
    din_async = 1'b0;
    ticks(8);
    check_now("sat_pre", 1'b0, 1'b0, 8'd0);
    for (int g = 1; g <= 300; g++) begin
      din_async = 1'b1;
      tick();
      din_async = 1'b0;
      ticks(3);
      if (g == 1 || g == 128 || g == 255 || g == 256 || g == 300) begin
        check_now($sformatf("sat_%0d", g), 1'b0, 1'b0, 8'((g > 255) ? 255 : g));
      end
    end
    ticks(2);
    check_now("sat_hold", 1'b0, 1'b0, 8'd255);

    compare("sb_drained", 8'(sb.size()), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
